// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line and configuration in, received-byte strobe and status out.
interface uart_rx_if #(
    parameter int unsigned DIV_WIDTH = 12
);
    logic                 rx;
    logic [DIV_WIDTH-1:0] baud_divider;
    logic                 parity_en;
    logic                 parity_type_odd;
    logic                 valid;
    logic [7:0]           data;
    logic                 parity_error;
    logic                 frame_error;
    logic                 busy;

    // Receiver side
    modport master (
        input  rx, baud_divider, parity_en, parity_type_odd,
        output valid, data, parity_error, frame_error, busy
    );

    // Line driver / byte consumer side
    modport slave (
        output rx, baud_divider, parity_en, parity_type_odd,
        input  valid, data, parity_error, frame_error, busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver core: oversampled start/data/parity/stop recovery with one-cycle valid pulse per frame.
// Configuration is latched at start detection so mid-frame register writes are harmless.
module uart_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DIV_WIDTH   = 12
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int unsigned DW = DIV_WIDTH;
    localparam int unsigned SW = SYNC_STAGES;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t         state_q, state_n;
    logic [SW-1:0]  sync_q;
    logic           rx_s;
    logic           rx_prev_q;
    logic [DW-1:0]  cnt_q, cnt_n;
    logic [DW-1:0]  div_q, div_n;
    logic [DW-1:0]  div_c;
    logic           pen_q, pen_n;
    logic           odd_q, odd_n;
    logic [2:0]     idx_q, idx_n;
    logic [7:0]     shift_q, shift_n;
    logic           perr_q, perr_n;
    logic           valid_q, valid_n;
    logic [7:0]     data_q, data_n;
    logic           parity_error_q, parity_error_n;
    logic           frame_error_q, frame_error_n;
    logic           busy_q, busy_n;
    logic           cnt_zero_c;

    // Metastability synchronizer; preset to idle-high so reset never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SW-2:0], bus.rx};
            rx_prev_q <= rx_s;
        end
    end

    assign rx_s       = sync_q[SW-1];
    assign div_c      = (bus.baud_divider < DW'(4)) ? DW'(4) : bus.baud_divider;
    assign cnt_zero_c = (cnt_q == '0);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            div_q          <= DW'(4);
            pen_q          <= 1'b0;
            odd_q          <= 1'b0;
            idx_q          <= '0;
            shift_q        <= '0;
            perr_q         <= 1'b0;
            valid_q        <= 1'b0;
            data_q         <= '0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_n;
            cnt_q          <= cnt_n;
            div_q          <= div_n;
            pen_q          <= pen_n;
            odd_q          <= odd_n;
            idx_q          <= idx_n;
            shift_q        <= shift_n;
            perr_q         <= perr_n;
            valid_q        <= valid_n;
            data_q         <= data_n;
            parity_error_q <= parity_error_n;
            frame_error_q  <= frame_error_n;
            busy_q         <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n        = state_q;
        cnt_n          = cnt_q;
        div_n          = div_q;
        pen_n          = pen_q;
        odd_n          = odd_q;
        idx_n          = idx_q;
        shift_n        = shift_q;
        perr_n         = perr_q;
        valid_n        = 1'b0;
        data_n         = data_q;
        parity_error_n = parity_error_q;
        frame_error_n  = frame_error_q;

        case (state_q)
            IDLE: begin
                // Only a genuine 1->0 transition starts a frame; a stuck-low line is ignored
                if (!rx_s && rx_prev_q) begin
                    div_n   = div_c;
                    pen_n   = bus.parity_en;
                    odd_n   = bus.parity_type_odd;
                    cnt_n   = (div_c >> 1) - DW'(1);
                    perr_n  = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt_zero_c) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = div_q - DW'(1);
                        idx_n   = '0;
                        state_n = DATA;
                    end
                end else begin
                    cnt_n = cnt_q - DW'(1);
                end
            end
            DATA: begin
                if (cnt_zero_c) begin
                    shift_n[idx_q] = rx_s;
                    cnt_n          = div_q - DW'(1);
                    if (idx_q == 3'd7) begin
                        state_n = pen_q ? PARITY : STOP;
                    end else begin
                        idx_n = idx_q + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_q - DW'(1);
                end
            end
            PARITY: begin
                if (cnt_zero_c) begin
                    perr_n  = (rx_s != ((^shift_q) ^ odd_q));
                    cnt_n   = div_q - DW'(1);
                    state_n = STOP;
                end else begin
                    cnt_n = cnt_q - DW'(1);
                end
            end
            STOP: begin
                if (cnt_zero_c) begin
                    valid_n        = 1'b1;
                    data_n         = shift_q;
                    parity_error_n = perr_q;
                    frame_error_n  = ~rx_s;
                    state_n        = IDLE;
                end else begin
                    cnt_n = cnt_q - DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.valid        = valid_q;
    assign bus.data         = data_q;
    assign bus.parity_error = parity_error_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.busy         = busy_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver core: recovers 8-bit frames from the asynchronous rx line and presents each received byte as a single-cycle valid pulse.
- Sits directly upstream of the receive FIFO in the buffered-RX path; valid/data feed the FIFO write port.
- No backpressure: the FIFO drops the byte if full.
- Configuration (baud_divider, parity) matches the existing uart_tx core, so a TX/RX pair shares one register set.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the rx input synchronizer (minimum 2).
- DIV_WIDTH, 12, width of baud_divider and the internal bit-period counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- valid  output  1  one-cycle pulse: data, parity_error, frame_error are valid
- data  output  8  received byte, LSB first on the line
- parity_error  output  1  qualified by valid: parity mismatch (0 when parity disabled)
- frame_error  output  1  qualified by valid: stop bit sampled low
- busy  output  1  high from start-edge detection until return to IDLE
- baud_divider  input  DIV_WIDTH  clock cycles per bit (D); values below 4 treated as 4
- parity_en  input  1  parity bit present after data bits
- parity_type_odd  input  1  1 = odd parity, 0 = even parity

Behaviour:
- Reset (async, rst high):
  - valid=0, data=8'h00, parity_error=0, frame_error=0, busy=0.
  - State=IDLE; synchronizer flops preset to 1 (line idle).
- Input path:
  - rx passes through SYNC_STAGES flops to give rx_s.
  - Only rx_s is used internally; no other logic touches raw rx.
- Config latch:
  - baud_divider, parity_en and parity_type_odd are captured on start detection.
  - Changes mid-frame have no effect until the next frame.
- State machine (states IDLE, START, DATA, PARITY, STOP):
  - IDLE:
    - busy=0.
    - When rx_s==0 and the previous rx_s==1 (falling edge): load counter with floor(D/2)-1, go to START, busy=1.
    - A line held low (e.g. after a frame error or break) never triggers; a 1 must be seen first.
  - START:
    - Counter decrements each cycle; at 0, sample rx_s (mid start bit).
    - If 1: false start; go to IDLE, no valid.
    - If 0: load counter with D-1, bit index=0, go to DATA.
  - DATA:
    - At each counter expiry, sample rx_s into shift register bit [index] (LSB first), then reload D-1.
    - After index 7: go to PARITY if parity_en, else STOP.
  - PARITY:
    - At expiry, sample parity bit.
    - Expected parity bit = XOR(data) for even; ~XOR(data) for odd.
    - Mismatch sets the internal perr flag; reload D-1, go to STOP.
  - STOP:
    - At expiry, sample rx_s; frame error = (rx_s==0).
    - Next cycle: valid=1 for exactly one cycle; data=shift register, parity_error=perr, frame_error as sampled.
    - Go to IDLE in that same cycle, busy=0.
- valid is asserted even on error; the error flags qualify the byte.
- Outputs data/parity_error/frame_error hold their values until the next valid.
- Latency:
  - Falling edge on rx at cycle 0 → valid high in cycle SYNC_STAGES + floor(D/2) + N·D + 1.
  - N = 9 without parity, 10 with parity.
- Back-to-back frames: the next start edge may occur the cycle after the stop sample; the receiver must catch it. Minimum gap between frames is 0 stop-bit extensions.
- Reset mid-frame: immediate return to IDLE, no valid, partial byte discarded.
- Counter arithmetic: unsigned DIV_WIDTH bits; D clamped to 4 before the load computation; no wrap possible.

Test Plan:
- D=16, no parity, send 8'hA5 with 1 stop bit → exactly one valid, data=8'hA5, both errors 0; valid at cycle 2+8+144+1=155 after the start edge.
- D=16, parity_en=1, odd, send 8'h03 with parity bit 1 → data=8'h03, parity_error=0. Repeat with parity bit 0 → parity_error=1, valid still asserted.
- D=16, send 8'h55 with stop bit driven 0 → frame_error=1, data=8'h55. Hold rx low 100 cycles → no further valid. Release to 1, then send 8'h12 → data=8'h12, frame_error=0.
- D=16, 4-cycle low glitch on idle rx → no valid, busy returns to 0 within 10 cycles.
- D=4 (min), send 8'h00, 8'hFF, 8'h81 back-to-back with zero idle between frames → three valid pulses, values in order, no errors.
- Assert rst during DATA bit 4 of a frame → all outputs 0 immediately. After reset release, a full 8'h3C frame is received correctly.
